param_sync_fifo: RTL and testbench
==================================

# param_sync_fifo

Parametrised single-clock FIFO that replaces the fixed 12-bit/8-entry buffer used between producer and consumer stages. It uses every entry, supports non-power-of-two depths, presents first-word-fall-through read data, and provides occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush. It sits on any same-clock streaming path that needs elastic buffering with back-pressure.

## Interface
- WIDTH, 12, data width in bits (>=1)
- DEPTH, 8, number of storage entries (>=2, any integer, not restricted to powers of two)
- AW, $clog2(DEPTH), pointer width (derived, do not override)
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 1, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read (pop) request
- rd_data  out  WIDTH  head-of-queue data, valid while empty=0
- flush  in  1  synchronous clear of queue contents
- clr_err  in  1  synchronous clear of overflow/underflow
- count  out  AW+1  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AEMPTY_TH
- almost_full  out  1  count >= AFULL_TH
- overflow  out  1  sticky: write rejected since last clear
- underflow  out  1  sticky: read rejected since last clear

## Operation
- State: storage array (not reset), wr_ptr, rd_ptr (0..DEPTH-1), count register, two sticky flags.
- rd_acc = rd_en & ~empty. wr_acc = wr_en & (~full | rd_acc): writing when full is accepted if a pop happens the same cycle.
- On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr advances. On rd_acc: rd_ptr advances. Pointer advance: value DEPTH-1 wraps to 0 (explicit compare, not modulo 2^AW).
- count <= count + wr_acc - rd_acc; both accepted -> count unchanged.
- rd_data = mem[rd_ptr] combinationally (FWFT); contents undefined while empty.
- overflow set when wr_en & ~wr_acc; underflow set when rd_en & empty. Rejected operations leave pointers, count and data untouched.
- clr_err clears both flags; a set event in the same cycle wins (flag remains 1).
- flush: wr_ptr, rd_ptr, count <= 0; overrides wr_en/rd_en that cycle (both dropped, no error flag set); does not affect overflow/underflow; clr_err still honoured.
- empty/full/almost_* and count decoded from the count register only: no combinational path from wr_en/rd_en to any status output.

## Timing
- Reset (async assert, any time, including mid-transfer): pointers 0, count 0, empty 1, full 0, almost_empty 1 (AEMPTY_TH>=0), almost_full 0, overflow 0, underflow 0; rd_data undefined. Deassertion is synchronised externally.
- Write-to-read latency 1: write accepted at edge N -> empty=0 and rd_data = written word during cycle after N.
- Pop at edge N -> next entry on rd_data after N; queue order strictly preserved across wrap.
- Status outputs and error flags change only on clk edges (or reset); all update in the same cycle as count.
- Sustained throughput: one write and one read per cycle at any occupancy except read while empty.

## Test plan
- Reset, then write 0x001..0x008 (DEPTH=8) -> almost_full after 6th write, full and count=8 after 8th; 9th write 0x009 -> overflow=1, count 8, contents unchanged.
- From full, read 8 times -> rd_data 0x001..0x008 in order, almost_empty at count 1, empty after 8th; extra read -> underflow=1, count 0.
- Full + wr_en&rd_en -> both accepted, count stays 8, tail = new word; empty + wr_en&rd_en -> write only, underflow=1, count 1.
- DEPTH=5: interleave 20 writes 0x100.. with reads keeping count 2..5 -> exact order across pointer wrap, full exactly at count 5.
- count=4, flush with wr_en=1 and overflow=1 -> count 0, empty 1, overflow stays 1; later clr_err together with rejected write -> overflow stays 1; clr_err alone -> 0.
- Assert rst_n=0 mid-cycle at count=5 -> count 0, empty 1, flags 0 immediately without waiting for an edge.

Source files
------------

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo
// Description : Single-clock FIFO with first-word-fall-through read data.
//               Supports any depth >= 2, uses every entry, and reports
//               occupancy, programmable almost-full/almost-empty, sticky
//               overflow/underflow, with a synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  input  logic             clr_err,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  // Pointers wrap on the last real entry, so non-power-of-two depths work.
  localparam logic [AW-1:0] c_PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   c_CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_AFULL = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0]   c_CNT_AEMPT = (AW + 1)'(AEMPTY_TH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW-1:0]    w_rd_ptr_nxt;

  // Status is decoded purely from the count register.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_CNT_FULL);

  // A write into a full FIFO is fine when a pop frees the head the same cycle.
  // Flush drops both requests and raises no error.
  assign w_rd_ok   = rd_en & ~w_empty;
  assign w_wr_ok   = wr_en & (~w_full | w_rd_ok);
  assign w_rd_acc  = w_rd_ok & ~flush;
  assign w_wr_acc  = w_wr_ok & ~flush;
  assign w_ovf_set = wr_en & ~w_wr_ok & ~flush;
  assign w_udf_set = rd_en & w_empty & ~flush;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking, with flush clearing the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a new error event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~clr_err) | w_ovf_set;
      r_underflow <= (r_underflow & ~clr_err) | w_udf_set;
    end
  end

  assign rd_data      = r_mem[r_rd_ptr];
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= c_CNT_AEMPT);
  assign almost_full  = (r_count >= c_CNT_AFULL);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sync_fifo
// Description : Directed self-checking bench for param_sync_fifo, using a
//               DEPTH=8 instance and a DEPTH=5 instance on a shared clock.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_param_sync_fifo;

  logic clk;
  logic rst_n;

  // DEPTH=8 instance signals
  logic        a_wr_en, a_rd_en, a_flush, a_clr_err;
  logic [11:0] a_wr_data, a_rd_data;
  logic [3:0]  a_count;
  logic        a_empty, a_full, a_almost_empty, a_almost_full, a_overflow, a_underflow;

  // DEPTH=5 instance signals
  logic        b_wr_en, b_rd_en, b_flush, b_clr_err;
  logic [11:0] b_wr_data, b_rd_data;
  logic [3:0]  b_count;
  logic        b_empty, b_full, b_almost_empty, b_almost_full, b_overflow, b_underflow;

  int n_checks;
  int n_errors;

  logic [11:0] q[$];
  logic [11:0] b_next;

  param_sync_fifo #(.WIDTH(12), .DEPTH(8)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (a_wr_en),
    .wr_data      (a_wr_data),
    .rd_en        (a_rd_en),
    .rd_data      (a_rd_data),
    .flush        (a_flush),
    .clr_err      (a_clr_err),
    .count        (a_count),
    .empty        (a_empty),
    .full         (a_full),
    .almost_empty (a_almost_empty),
    .almost_full  (a_almost_full),
    .overflow     (a_overflow),
    .underflow    (a_underflow)
  );

  param_sync_fifo #(.WIDTH(12), .DEPTH(5)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (b_wr_en),
    .wr_data      (b_wr_data),
    .rd_en        (b_rd_en),
    .rd_data      (b_rd_data),
    .flush        (b_flush),
    .clr_err      (b_clr_err),
    .count        (b_count),
    .empty        (b_empty),
    .full         (b_full),
    .almost_empty (b_almost_empty),
    .almost_full  (b_almost_full),
    .overflow     (b_overflow),
    .underflow    (b_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_push();
    b_wr_en   = 1'b1;
    b_wr_data = b_next;
    q.push_back(b_next);
    b_next    = b_next + 12'd1;
    tick();
    b_wr_en   = 1'b0;
    check("b_push_count", 32'(b_count), 32'(q.size()));
    check("b_push_full", 32'(b_full), 32'(q.size() == 5));
    check("b_push_afull", 32'(b_almost_full), 32'(q.size() >= 3));
    check("b_push_head", 32'(b_rd_data), 32'(q[0]));
  endtask

  task automatic b_pop();
    check("b_pop_data", 32'(b_rd_data), 32'(q[0]));
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
    void'(q.pop_front());
    check("b_pop_count", 32'(b_count), 32'(q.size()));
    check("b_pop_empty", 32'(b_empty), 32'(q.size() == 0));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    a_wr_en = 0; a_rd_en = 0; a_flush = 0; a_clr_err = 0; a_wr_data = '0;
    b_wr_en = 0; b_rd_en = 0; b_flush = 0; b_clr_err = 0; b_wr_data = '0;
    b_next = 12'h100;

    // Reset state
    repeat (2) tick();
    check("rst_count", 32'(a_count), 0);
    check("rst_empty", 32'(a_empty), 1);
    check("rst_full", 32'(a_full), 0);
    check("rst_aempty", 32'(a_almost_empty), 1);
    check("rst_afull", 32'(a_almost_full), 0);
    check("rst_ovf", 32'(a_overflow), 0);
    check("rst_udf", 32'(a_underflow), 0);
    rst_n = 1'b1;
    tick();

    // Fill 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      a_wr_en = 1'b1; a_wr_data = 12'(i);
      tick();
      check("fill_count", 32'(a_count), 32'(i));
      check("fill_afull", 32'(a_almost_full), 32'(i >= 6));
      check("fill_full", 32'(a_full), 32'(i == 8));
      check("fill_empty", 32'(a_empty), 0);
      check("fill_head", 32'(a_rd_data), 32'h001);
    end
    // Rejected 9th write
    a_wr_data = 12'h009;
    tick();
    a_wr_en = 1'b0;
    check("ovf_flag", 32'(a_overflow), 1);
    check("ovf_count", 32'(a_count), 8);
    check("ovf_head", 32'(a_rd_data), 32'h001);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", 32'(a_rd_data), 32'(i));
      a_rd_en = 1'b1;
      tick();
      check("drain_count", 32'(a_count), 32'(8 - i));
      check("drain_aempty", 32'(a_almost_empty), 32'((8 - i) <= 1));
      check("drain_empty", 32'(a_empty), 32'(i == 8));
    end
    // Extra read
    tick();
    a_rd_en = 1'b0;
    check("udf_flag", 32'(a_underflow), 1);
    check("udf_count", 32'(a_count), 0);

    a_clr_err = 1'b1;
    tick();
    a_clr_err = 1'b0;
    check("clr_ovf", 32'(a_overflow), 0);
    check("clr_udf", 32'(a_underflow), 0);

    // Full with simultaneous read and write
    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1'b1; a_wr_data = 12'h010 + 12'(i);
      tick();
    end
    check("full2", 32'(a_full), 1);
    a_wr_data = 12'h0AA; a_rd_en = 1'b1;
    tick();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    check("rw_full_count", 32'(a_count), 8);
    check("rw_full_ovf", 32'(a_overflow), 0);
    check("rw_full_head", 32'(a_rd_data), 32'h011);
    for (int i = 0; i < 8; i++) begin
      check("rw_drain_data", 32'(a_rd_data), (i == 7) ? 32'h0AA : 32'h011 + 32'(i));
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
    end
    check("rw_drain_empty", 32'(a_empty), 1);

    // Empty with simultaneous read and write
    a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 12'h0BB;
    tick();
    a_rd_en = 1'b0; a_wr_en = 1'b0;
    check("rw_empty_count", 32'(a_count), 1);
    check("rw_empty_udf", 32'(a_underflow), 1);
    check("rw_empty_data", 32'(a_rd_data), 32'h0BB);

    // Reach full, overflow, then back to count 4
    for (int i = 1; i <= 7; i++) begin
      a_wr_en = 1'b1; a_wr_data = 12'h0C0 + 12'(i);
      tick();
    end
    a_wr_data = 12'h0FF;
    tick();
    a_wr_en = 1'b0;
    check("pre_flush_ovf", 32'(a_overflow), 1);
    a_rd_en = 1'b1;
    repeat (4) tick();
    a_rd_en = 1'b0;
    check("pre_flush_count", 32'(a_count), 4);
    check("pre_flush_head", 32'(a_rd_data), 32'h0C4);

    // Flush overrides a write and keeps the sticky flags
    a_flush = 1'b1; a_wr_en = 1'b1; a_wr_data = 12'h0EE;
    tick();
    a_flush = 1'b0; a_wr_en = 1'b0;
    check("flush_count", 32'(a_count), 0);
    check("flush_empty", 32'(a_empty), 1);
    check("flush_ovf", 32'(a_overflow), 1);
    check("flush_udf", 32'(a_underflow), 1);

    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1'b1; a_wr_data = 12'h0D0 + 12'(i);
      tick();
    end
    check("refill_head", 32'(a_rd_data), 32'h0D0);
    // Clear racing with a rejected write: overflow stays, underflow clears
    a_clr_err = 1'b1; a_wr_data = 12'h0DD;
    tick();
    a_wr_en = 1'b0;
    check("clr_race_ovf", 32'(a_overflow), 1);
    check("clr_race_udf", 32'(a_underflow), 0);
    tick();
    a_clr_err = 1'b0;
    check("clr_alone_ovf", 32'(a_overflow), 0);
    check("clr_keep_count", 32'(a_count), 8);

    // DEPTH=5: interleaved traffic across pointer wrap
    for (int i = 0; i < 5; i++) b_push();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) b_pop();
      for (int i = 0; i < 3; i++) b_push();
    end
    for (int i = 0; i < 5; i++) b_pop();
    check("b_final_next", 32'(b_next), 32'h114);
    check("b_ovf", 32'(b_overflow), 0);

    // Asynchronous reset mid-cycle at count 5 with overflow set
    a_wr_en = 1'b1; a_wr_data = 12'h0AB;
    tick();
    a_wr_en = 1'b0;
    check("pre_rst_ovf", 32'(a_overflow), 1);
    a_rd_en = 1'b1;
    repeat (3) tick();
    a_rd_en = 1'b0;
    check("pre_rst_count", 32'(a_count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(a_count), 0);
    check("arst_empty", 32'(a_empty), 1);
    check("arst_aempty", 32'(a_almost_empty), 1);
    check("arst_ovf", 32'(a_overflow), 0);
    check("arst_udf", 32'(a_underflow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
